mat_loader: RTL

MAT_LOADER -- requirements
Module: mat_loader

---
 rtl/mat_loader_if.sv | 24 ++
 rtl/mat_loader.sv | 111 +++++++++++
 2 files changed

// File: rtl/mat_loader_if.sv
// Element stream in, committed operand pair out, for the matrix operand loader.
interface mat_loader_if #(
   parameter int W_IN = 8,
   parameter int N    = 2
);
   logic                                 s_valid;
   logic                                 s_ready;
   logic signed [W_IN-1:0]               s_data;
   logic                                 flush;
   logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_1;
   logic signed [N-1:0][N-1:0][W_IN-1:0] matrix_2;
   logic                                 valid_out;
   logic                                 busy;

   modport master (
      output s_valid, s_data, flush,
      input  s_ready, matrix_1, matrix_2, valid_out, busy
   );

   modport slave (
      input  s_valid, s_data, flush,
      output s_ready, matrix_1, matrix_2, valid_out, busy
   );
endinterface

// File: rtl/mat_loader.sv
// Collects two N x N matrices beat by beat (row-major, left operand first) into
// shadow buffers and commits the pair to the outputs atomically.
module mat_loader #(
   parameter int W_IN = 8,
   parameter int N    = 2
) (
   input  logic         clk,
   input  logic         resetn,
   mat_loader_if.slave  bus
);
   localparam int NN    = N * N;
   localparam int LOG2N = $clog2(N);
   localparam int KW    = 2 * LOG2N;

   typedef enum logic [1:0] {
      LOAD_A = 2'd0,
      LOAD_B = 2'd1,
      EMIT   = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [KW-1:0]   k_reg, k_next;
   logic            accept;
   logic            last_beat;
   logic            commit;

   // s_ready is forced low during reset so nothing is taken while the loader is held.
   assign bus.s_ready = resetn && (state_reg != EMIT) && !bus.flush;
   assign accept      = bus.s_valid && bus.s_ready;
   assign last_beat   = (k_reg == KW'(NN - 1));
   assign commit      = accept && last_beat && (state_reg == LOAD_B);

   assign bus.valid_out = (state_reg == EMIT);
   assign bus.busy      = (state_reg == LOAD_B) || ((state_reg == LOAD_A) && (k_reg != '0));

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= LOAD_A;
         k_reg     <= '0;
      end else begin
         state_reg <= state_next;
         k_reg     <= k_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      k_next     = k_reg;
      case (state_reg)
         LOAD_A, LOAD_B: begin
            if (bus.flush) begin
               state_next = LOAD_A;
               k_next     = '0;
            end else if (accept) begin
               if (last_beat) begin
                  state_next = (state_reg == LOAD_A) ? LOAD_B : EMIT;
                  k_next     = '0;
               end else begin
                  k_next = k_reg + KW'(1);
               end
            end
         end
         EMIT: begin
            state_next = LOAD_A;
            k_next     = '0;
         end
         default: begin
            state_next = LOAD_A;
            k_next     = '0;
         end
      endcase
   end

   // One storage slice per element; beat k lands in row k/N, column k%N.
   // A flushed partial load needs no clearing: every element is rewritten before the next commit.
   genvar gi;
   generate
      for (gi = 0; gi < NN; gi++) begin : g_elem
         localparam int R = gi / N;
         localparam int C = gi % N;

         logic            hit;
         logic [W_IN-1:0] shadow_a_reg;
         logic [W_IN-1:0] shadow_b_reg;
         logic [W_IN-1:0] matrix_1_reg;
         logic [W_IN-1:0] matrix_2_reg;

         assign hit = accept && (k_reg == KW'(gi));

         always_ff @(posedge clk or negedge resetn) begin
            if (!resetn) begin
               shadow_a_reg <= '0;
               shadow_b_reg <= '0;
               matrix_1_reg <= '0;
               matrix_2_reg <= '0;
            end else begin
               if (hit && (state_reg == LOAD_A)) shadow_a_reg <= bus.s_data;
               if (hit && (state_reg == LOAD_B)) shadow_b_reg <= bus.s_data;
               // The final beat of matrix_2 is still in flight at commit, so bypass it.
               if (commit) begin
                  matrix_1_reg <= shadow_a_reg;
                  matrix_2_reg <= hit ? bus.s_data : shadow_b_reg;
               end
            end
         end

         assign bus.matrix_1[R][C] = matrix_1_reg;
         assign bus.matrix_2[R][C] = matrix_2_reg;
      end
   endgenerate
endmodule
